// File: rtl/dff_rs_monitor_if.sv
// Observation bus of one asynchronous set/reset D flip-flop: the stimulus side
// drives the flop pins, the monitor watches them.
interface dff_rs_monitor_if;
    logic mon_d;
    logic mon_set_n;
    logic mon_reset_n;
    logic mon_q;

    modport master (
        output mon_d,
        output mon_set_n,
        output mon_reset_n,
        output mon_q
    );

    modport slave (
        input mon_d,
        input mon_set_n,
        input mon_reset_n,
        input mon_q
    );
endinterface

// File: rtl/dff_rs_monitor.sv
// Passive checker for an async set/reset D flip-flop: predicts q every edge,
// flags mismatches, counts errors and compared samples, keeps a sticky fail.
module dff_rs_monitor #(
    parameter int CNT_W    = 8,
    parameter bit RST_PRIO = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    dff_rs_monitor_if.slave    obs,
    output logic               exp_q,
    output logic               err,
    output logic               fail,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   chk_cnt,
    output logic               valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int               N_CNT   = 2;

    // ARM is the classification of the first enabled edge; it lasts only that
    // edge, so the registered state moves straight from IDLE to CHECK.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;
    state_t edge_state;

    logic m_q_reg;
    logic m_q_next;
    logic exp_q_reg;
    logic exp_q_next;
    logic err_reg;
    logic err_next;
    logic fail_reg;
    logic fail_next;

    logic force_act;
    logic force_val;
    logic do_check;
    logic mismatch;

    logic [N_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_val [N_CNT];

    // Reference model: async controls override the registered prediction on
    // the same edge, exactly as they act on the real flop immediately.
    always_comb begin
        force_act = 1'b0;
        force_val = 1'b0;
        if (!obs.mon_reset_n && (RST_PRIO || obs.mon_set_n)) begin
            force_act = 1'b1;
            force_val = 1'b0;
        end else if (!obs.mon_set_n) begin
            force_act = 1'b1;
            force_val = 1'b1;
        end
        exp_q_next = force_act ? force_val : m_q_reg;
        m_q_next   = force_act ? force_val : obs.mon_d;
    end

    // FSM next state and classification of the edge being sampled.
    always_comb begin
        edge_state = IDLE;
        state_next = IDLE;
        if (en) begin
            state_next = CHECK;
            if (state_reg == CHECK) begin
                edge_state = CHECK;
            end else begin
                edge_state = ARM;
            end
        end
    end

    // Case equality so an undriven or unknown q is reported as a mismatch.
    always_comb begin
        do_check  = (edge_state == CHECK);
        mismatch  = do_check && (obs.mon_q !== exp_q_next);
        err_next  = mismatch;
        fail_next = fail_reg | mismatch;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            m_q_reg   <= 1'b0;
            exp_q_reg <= 1'b0;
            err_reg   <= 1'b0;
            fail_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_q_reg   <= m_q_next;
            exp_q_reg <= exp_q_next;
            err_reg   <= err_next;
            fail_reg  <= fail_next;
        end
    end

    // Index 0 counts compared samples, index 1 counts mismatches.
    assign cnt_inc = {mismatch, do_check};

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign exp_q   = exp_q_reg;
    assign err     = err_reg;
    assign fail    = fail_reg;
    assign chk_cnt = cnt_val[0];
    assign err_cnt = cnt_val[1];
    assign valid   = (state_reg == CHECK);

endmodule

// File: tb/tb_dff_rs_monitor.sv
// Bench for dff_rs_monitor: one monitor with reset priority and one with set
// priority watch the same bus; table vectors, corner sequences, random run.
module tb_dff_rs_monitor;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic en;

    always #5 clk = ~clk;

    dff_rs_monitor_if bus();

    logic             exp_q_rp, err_rp, fail_rp, valid_rp;
    logic [CNT_W-1:0] err_cnt_rp, chk_cnt_rp;
    logic             exp_q_sp, err_sp, fail_sp, valid_sp;
    logic [CNT_W-1:0] err_cnt_sp, chk_cnt_sp;

    dff_rs_monitor #(.CNT_W(CNT_W), .RST_PRIO(1'b1)) dut_rp (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .obs     (bus),
        .exp_q   (exp_q_rp),
        .err     (err_rp),
        .fail    (fail_rp),
        .err_cnt (err_cnt_rp),
        .chk_cnt (chk_cnt_rp),
        .valid   (valid_rp)
    );

    dff_rs_monitor #(.CNT_W(CNT_W), .RST_PRIO(1'b0)) dut_sp (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .obs     (bus),
        .exp_q   (exp_q_sp),
        .err     (err_sp),
        .fail    (fail_sp),
        .err_cnt (err_cnt_sp),
        .chk_cnt (chk_cnt_sp),
        .valid   (valid_sp)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural reference; index 0 = reset-priority monitor, 1 = set-priority.
    bit m_cap   [2];
    int run_len [2];
    int me_cnt  [2];
    int mc_cnt  [2];
    bit m_fail  [2];
    bit m_err   [2];
    bit m_exp   [2];
    bit m_valid [2];

    typedef struct packed {
        logic en, d, s, r, q, eq_rp, er_rp, eq_sp, er_sp;
    } vec_t;
    vec_t tbl [12];

    task automatic cmp(input string name, input int p, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d expected=%0d", name, p, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_edge();
        for (int p = 0; p < 2; p++) begin
            int fv;
            bit prio;
            prio = (p == 0);
            if (!reset_n) begin
                m_cap[p] = 0; run_len[p] = 0; me_cnt[p] = 0; mc_cnt[p] = 0;
                m_fail[p] = 0; m_err[p] = 0; m_exp[p] = 0; m_valid[p] = 0;
            end else begin
                if (!bus.mon_reset_n && (prio || bus.mon_set_n)) fv = 0;
                else if (!bus.mon_set_n) fv = 1;
                else fv = -1;
                m_exp[p]   = (fv >= 0) ? fv[0] : m_cap[p];
                run_len[p] = en ? ((run_len[p] >= 2) ? 2 : run_len[p] + 1) : 0;
                m_err[p]   = 0;
                if (run_len[p] >= 2) begin
                    mc_cnt[p] = sat(mc_cnt[p] + 1);
                    if (bus.mon_q !== m_exp[p]) begin
                        m_err[p]  = 1;
                        me_cnt[p] = sat(me_cnt[p] + 1);
                        m_fail[p] = 1;
                    end
                end
                m_cap[p]   = (fv >= 0) ? fv[0] : bus.mon_d;
                m_valid[p] = (run_len[p] >= 1);
            end
        end
    endtask

    task automatic check_model();
        cmp("exp_q",   0, 32'(exp_q_rp),   32'(m_exp[0]));
        cmp("err",     0, 32'(err_rp),     32'(m_err[0]));
        cmp("fail",    0, 32'(fail_rp),    32'(m_fail[0]));
        cmp("valid",   0, 32'(valid_rp),   32'(m_valid[0]));
        cmp("err_cnt", 0, 32'(err_cnt_rp), 32'(me_cnt[0]));
        cmp("chk_cnt", 0, 32'(chk_cnt_rp), 32'(mc_cnt[0]));
        cmp("exp_q",   1, 32'(exp_q_sp),   32'(m_exp[1]));
        cmp("err",     1, 32'(err_sp),     32'(m_err[1]));
        cmp("fail",    1, 32'(fail_sp),    32'(m_fail[1]));
        cmp("valid",   1, 32'(valid_sp),   32'(m_valid[1]));
        cmp("err_cnt", 1, 32'(err_cnt_sp), 32'(me_cnt[1]));
        cmp("chk_cnt", 1, 32'(chk_cnt_sp), 32'(mc_cnt[1]));
    endtask

    task automatic step(input bit e, input bit d, input bit s, input bit r, input bit q);
        en              = e;
        bus.mon_d       = d;
        bus.mon_set_n   = s;
        bus.mon_reset_n = r;
        bus.mon_q       = q;
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        $display("t=%0t rst_n=%b en=%b d=%b s_n=%b r_n=%b q=%b | rp exp=%b err=%b e=%0d c=%0d | sp exp=%b err=%b e=%0d c=%0d",
                 $time, reset_n, e, d, s, r, q, exp_q_rp, err_rp, err_cnt_rp, chk_cnt_rp,
                 exp_q_sp, err_sp, err_cnt_sp, chk_cnt_sp);
    endtask

    initial begin
        bit fl_cap;
        bit d, s, r, q;

        //               en d s r q eqr err eqs ers
        tbl[0]  = 9'b1_0_1_1_0_0_0_0_0;
        tbl[1]  = 9'b1_1_1_1_0_0_0_0_0;
        tbl[2]  = 9'b1_1_1_1_1_1_0_1_0;
        tbl[3]  = 9'b1_0_1_1_1_1_0_1_0;
        tbl[4]  = 9'b1_0_1_1_0_0_0_0_0;
        tbl[5]  = 9'b1_1_1_0_0_0_0_0_0;
        tbl[6]  = 9'b1_1_1_0_0_0_0_0_0;
        tbl[7]  = 9'b1_1_1_1_0_0_0_0_0;
        tbl[8]  = 9'b1_1_1_1_0_1_1_1_1;
        tbl[9]  = 9'b1_0_0_0_0_0_0_1_1;
        tbl[10] = 9'b1_0_0_1_1_1_0_1_0;
        tbl[11] = 9'b1_0_1_1_1_1_0_1_0;

        en = 1'b0;
        bus.mon_d = 1'b0; bus.mon_set_n = 1'b1; bus.mon_reset_n = 1'b1; bus.mon_q = 1'b0;

        // Monitor reset with a would-be mismatch present: reset wins.
        reset_n = 1'b0;
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].en, tbl[i].d, tbl[i].s, tbl[i].r, tbl[i].q);
            cmp($sformatf("tbl%0d_exp_q", i), 0, 32'(exp_q_rp), 32'(tbl[i].eq_rp));
            cmp($sformatf("tbl%0d_err", i),   0, 32'(err_rp),   32'(tbl[i].er_rp));
            cmp($sformatf("tbl%0d_exp_q", i), 1, 32'(exp_q_sp), 32'(tbl[i].eq_sp));
            cmp($sformatf("tbl%0d_err", i),   1, 32'(err_sp),   32'(tbl[i].er_sp));
            if (i == 4) begin
                cmp("first5_chk_cnt", 0, 32'(chk_cnt_rp), 32'd4);
                cmp("first5_err_cnt", 0, 32'(err_cnt_rp), 32'd0);
                cmp("first5_fail",    0, 32'(fail_rp),    32'd0);
                cmp("first5_valid",   0, 32'(valid_rp),   32'd1);
            end
        end
        cmp("tbl_err_cnt", 0, 32'(err_cnt_rp), 32'd1);
        cmp("tbl_err_cnt", 1, 32'(err_cnt_sp), 32'd2);
        cmp("tbl_chk_cnt", 0, 32'(chk_cnt_rp), 32'd11);
        cmp("tbl_fail",    0, 32'(fail_rp),    32'd1);

        // Disable with wrong q for 3 edges, then one unchecked ARM edge.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 1);
            cmp("dis_valid", 0, 32'(valid_rp), 32'd0);
        end
        step(1, 0, 1, 1, 1);
        cmp("arm_chk_cnt", 0, 32'(chk_cnt_rp), 32'd11);
        cmp("arm_err_cnt", 0, 32'(err_cnt_rp), 32'd1);
        cmp("arm_valid",   0, 32'(valid_rp),   32'd1);
        step(1, 0, 1, 1, 0);
        cmp("resume_chk_cnt", 0, 32'(chk_cnt_rp), 32'd12);

        // Stuck-at-1 q with d=0 long enough to saturate both counters.
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 1, 1, 1);
            cmp("stuck_err", 0, 32'(err_rp), 32'd1);
        end
        cmp("sat_err_cnt", 0, 32'(err_cnt_rp), 32'(CMAX));
        cmp("sat_chk_cnt", 0, 32'(chk_cnt_rp), 32'(CMAX));
        cmp("sat_fail",    0, 32'(fail_rp),    32'd1);

        // Build err_cnt=5, then a single reset edge clears everything.
        reset_n = 1'b0;
        step(1, 0, 1, 1, 0);
        reset_n = 1'b1;
        step(1, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 1);
        cmp("pre_rst_err_cnt", 0, 32'(err_cnt_rp), 32'd5);
        reset_n = 1'b0;
        step(1, 0, 1, 1, 1);
        reset_n = 1'b1;
        cmp("rst_fail",    0, 32'(fail_rp),    32'd0);
        cmp("rst_err_cnt", 0, 32'(err_cnt_rp), 32'd0);
        cmp("rst_chk_cnt", 0, 32'(chk_cnt_rp), 32'd0);
        cmp("rst_valid",   0, 32'(valid_rp),   32'd0);
        step(1, 0, 1, 1, 1);
        cmp("post_rst_arm_chk", 0, 32'(chk_cnt_rp), 32'd0);

        // Random run: a behavioural flop drives q, with occasional corruption.
        fl_cap = 1'b0;
        for (int i = 0; i < 500; i++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            d = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 5) != 0);
            r = ($urandom_range(0, 5) != 0);
            q = !r ? 1'b0 : (!s ? 1'b1 : fl_cap);
            fl_cap = !r ? 1'b0 : (!s ? 1'b1 : d);
            if ($urandom_range(0, 9) == 0) q = ~q;
            step(($urandom_range(0, 9) != 0), d, s, r, q);
        end
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
